// File: rtl/clock_lock_pkg.sv
// Shared types and default constants for the clock lock sequencer.
//   lock_state_e : 2-bit FSM state encoding, visible on the top-level state port.
//   DEFAULT_*    : nominal parameter values for the 3.579545 MHz reference.
package clock_lock_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_MEASURE   = 2'd1,
      ST_RUN       = 2'd2,
      ST_FAULT     = 2'd3
   } lock_state_e;

   localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
   localparam int unsigned DEFAULT_RATIO          = 36;
   localparam int unsigned DEFAULT_TOLERANCE      = 2;
   localparam int unsigned DEFAULT_STABLE_PERIODS = 16;
   localparam int unsigned DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/clock_lock_sequencer_sync_edge.sv
// N-stage synchronizer for an asynchronous level, plus registered
// one-cycle rise/fall strobes.
//   clk, n_reset : clock and synchronous active-low reset
//   async_in     : asynchronous input level
//   sync_out     : synchronized level (last synchronizer stage)
//   rise, fall   : one-cycle strobes, SYNC_STAGES+1 cycles after the input edge
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Shift chain, edge-detect flop, strobe generation
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = rise_q;
   assign fall     = fall_q;

endmodule

// File: rtl/clock_lock_sequencer.sv
// Qualifies the PLL lock flag and the MSX reference clock, measures the
// clk-per-reference-period ratio, and releases the system reset once the
// ratio has been stable for STABLE_PERIODS consecutive periods.
//   clk, n_reset  : PLL output clock, synchronous active-low reset
//   pll_lock      : asynchronous PLL lock flag
//   ref_clk_in    : asynchronous reference clock, sampled as data
//   sys_n_reset   : registered active-low system reset (1 only in RUN)
//   ref_rise/fall : one-cycle strobes on synchronized reference edges
//   period_count  : last completed period measurement
//   freq_error    : sticky frequency fault flag
//   state         : FSM state (0 WAIT_LOCK, 1 MEASURE, 2 RUN, 3 FAULT)
module clock_lock_sequencer
   import clock_lock_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter int unsigned RATIO          = DEFAULT_RATIO,
   parameter int unsigned TOLERANCE      = DEFAULT_TOLERANCE,
   parameter int unsigned STABLE_PERIODS = DEFAULT_STABLE_PERIODS,
   parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             pll_lock,
   input  logic             ref_clk_in,
   output logic             sys_n_reset,
   output logic             ref_rise,
   output logic             ref_fall,
   output logic [CNT_W-1:0] period_count,
   output logic             freq_error,
   output logic [1:0]       state
);

   localparam int unsigned       GOOD_W      = $clog2(STABLE_PERIODS + 1);
   localparam logic [CNT_W-1:0]  WDOG_LIMIT  = CNT_W'(2 * RATIO);
   localparam logic [CNT_W-1:0]  PERIOD_MIN  = CNT_W'(RATIO - TOLERANCE);
   localparam logic [CNT_W-1:0]  PERIOD_MAX  = CNT_W'(RATIO + TOLERANCE);
   localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(STABLE_PERIODS);

   logic lock_sync;
   logic lock_rise_unused;
   logic lock_fall_unused;
   logic ref_level_unused;

   lock_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic              armed_q, armed_d;
   logic              freq_error_q, freq_error_d;
   logic              sys_n_reset_q, sys_n_reset_d;

   logic              wdog_c;
   logic              active_c;
   logic              eval_c;
   logic              good_c;
   logic [GOOD_W-1:0] good_inc_c;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk      (clk),
      .n_reset  (n_reset),
      .async_in (pll_lock),
      .sync_out (lock_sync),
      .rise     (lock_rise_unused),
      .fall     (lock_fall_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
      .clk      (clk),
      .n_reset  (n_reset),
      .async_in (ref_clk_in),
      .sync_out (ref_level_unused),
      .rise     (ref_rise),
      .fall     (ref_fall)
   );

   // Watchdog fires when the counter reaches 2*RATIO without a reference edge
   assign wdog_c     = (cnt_q == WDOG_LIMIT);
   assign active_c   = (state_q == ST_MEASURE) || (state_q == ST_RUN);
   // The first edge after entering MEASURE only starts the count; watchdog
   // expiry is always a genuine measurement of a dead reference
   assign eval_c     = active_c && (wdog_c || (ref_rise && armed_q));
   assign good_c     = !wdog_c && (cnt_q >= PERIOD_MIN) && (cnt_q <= PERIOD_MAX);
   assign good_inc_c = good_q + GOOD_W'(1);

   // Period counter, measurement latch and sequencing FSM
   always_comb begin
      cnt_d         = cnt_q + CNT_W'(1);
      period_d      = period_q;
      state_d       = state_q;
      good_d        = good_q;
      armed_d       = armed_q;
      freq_error_d  = freq_error_q;
      sys_n_reset_d = 1'b0;

      if (ref_rise || wdog_c) begin
         cnt_d = CNT_W'(1);
      end
      if (eval_c || wdog_c) begin
         period_d = cnt_q;
      end
      if (active_c && (ref_rise || wdog_c)) begin
         armed_d = 1'b1;
      end

      case (state_q)
         ST_WAIT_LOCK: begin
            good_d  = '0;
            armed_d = 1'b0;
            if (lock_sync) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (eval_c) begin
               if (good_c) begin
                  good_d = good_inc_c;
                  if (good_inc_c == GOOD_TARGET) begin
                     state_d      = ST_RUN;
                     freq_error_d = 1'b0;
                  end
               end else begin
                  good_d = '0;
               end
            end
         end
         ST_RUN: begin
            if (eval_c && !good_c) begin
               state_d      = ST_FAULT;
               freq_error_d = 1'b1;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_WAIT_LOCK;
         end
      endcase

      // Lock loss overrides every other event, and no fault is recorded
      if (!lock_sync) begin
         state_d      = ST_WAIT_LOCK;
         freq_error_d = freq_error_q;
      end

      sys_n_reset_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q       <= ST_WAIT_LOCK;
         cnt_q         <= '0;
         period_q      <= '0;
         good_q        <= '0;
         armed_q       <= 1'b0;
         freq_error_q  <= 1'b0;
         sys_n_reset_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         period_q      <= period_d;
         good_q        <= good_d;
         armed_q       <= armed_d;
         freq_error_q  <= freq_error_d;
         sys_n_reset_q <= sys_n_reset_d;
      end
   end

   assign sys_n_reset  = sys_n_reset_q;
   assign period_count = period_q;
   assign freq_error   = freq_error_q;
   assign state        = state_q;

endmodule

// File: tb/tb_clock_lock_sequencer.sv
// Directed bench for clock_lock_sequencer. Reference periods are driven in
// whole clk cycles; each driven rising edge pushes the period it completes
// onto a scoreboard that is popped when the DUT strobes ref_rise.
module tb_clock_lock_sequencer;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             n_reset;
   logic             pll_lock;
   logic             ref_clk_in;
   logic             sys_n_reset;
   logic             ref_rise;
   logic             ref_fall;
   logic [CNT_W-1:0] period_count;
   logic             freq_error;
   logic [1:0]       state;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      bit          chk;
      int unsigned exp_len;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   sb_entry_t   mon_e;
   bit          tb_eval  = 1'b0;
   int unsigned prev_len = 0;
   bit          pend     = 1'b0;

   always #5 clk = ~clk;

   clock_lock_sequencer #(
      .SYNC_STAGES    (2),
      .RATIO          (36),
      .TOLERANCE      (2),
      .STABLE_PERIODS (16),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .pll_lock     (pll_lock),
      .ref_clk_in   (ref_clk_in),
      .sys_n_reset  (sys_n_reset),
      .ref_rise     (ref_rise),
      .ref_fall     (ref_fall),
      .period_count (period_count),
      .freq_error   (freq_error),
      .state        (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: compare period_count the cycle after each ref_rise strobe
   always @(negedge clk) begin
      if (pend) begin
         check("rise_width", ref_rise, 0);
         checks++;
         assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_rise: observed=%0d expected=%0d", 0, 1);
         end
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check("period_count", period_count, mon_e.exp_len);
         end
      end
      pend = ref_rise;
   end

   initial begin
      #500000;
      $display("FAIL timeout: observed=%0d expected=%0d", 1, 0);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic rise_edge();
      sb_entry_t e;
      e.chk     = tb_eval;
      e.exp_len = prev_len;
      sb_q.push_back(e);
      tb_eval    = 1'b1;
      ref_clk_in = 1'b1;
   endtask

   task automatic finish_period(input int n, input int spent);
      wait_cycles(n / 2 - spent);
      ref_clk_in = 1'b0;
      wait_cycles(n - n / 2);
      prev_len = n;
   endtask

   task automatic drive_period(input int n);
      rise_edge();
      finish_period(n, 0);
   endtask

   // n ideal periods, then the rise that completes the 16th good period
   task automatic release_seq(input int n);
      for (int i = 0; i < n; i++) drive_period(36);
      sample();
      check("pre_release_state", state, 1);
      rise_edge();
      wait_cycles(3);
      sample();
      check("release_strobe", ref_rise, 1);
      check("release_strobe_state", state, 1);
      step();
      sample();
      check("release_state", state, 2);
      check("release_sys_n_reset", sys_n_reset, 1);
      check("release_freq_error", freq_error, 0);
      finish_period(36, 4);
   endtask

   initial begin
      // Reset values
      n_reset    = 1'b0;
      pll_lock   = 1'b1;
      ref_clk_in = 1'b0;
      wait_cycles(3);
      sample();
      check("rst_sys_n_reset", sys_n_reset, 0);
      check("rst_ref_rise", ref_rise, 0);
      check("rst_ref_fall", ref_fall, 0);
      check("rst_period_count", period_count, 0);
      check("rst_freq_error", freq_error, 0);
      check("rst_state", state, 0);
      n_reset = 1'b1;
      wait_cycles(10);
      sample();
      check("measure_state", state, 1);
      check("measure_sys_n_reset", sys_n_reset, 0);

      // First edge: strobe latency and width for both edges
      step();
      tb_eval = 1'b0;
      rise_edge();
      wait_cycles(2);
      sample();
      check("rise_early", ref_rise, 0);
      step();
      sample();
      check("rise_latency", ref_rise, 1);
      step();
      sample();
      check("rise_after", ref_rise, 0);
      wait_cycles(14);
      ref_clk_in = 1'b0;
      wait_cycles(2);
      sample();
      check("fall_early", ref_fall, 0);
      step();
      sample();
      check("fall_latency", ref_fall, 1);
      step();
      sample();
      check("fall_after", ref_fall, 0);
      wait_cycles(14);
      prev_len = 36;
      release_seq(15);
      check("run_period_count", period_count, 36);

      // RUN: tolerance edges are accepted, a 40-cycle period faults
      drive_period(34);
      drive_period(38);
      drive_period(36);
      drive_period(40);
      rise_edge();
      wait_cycles(3);
      sample();
      check("pre_fault_state", state, 2);
      step();
      sample();
      check("fault_state", state, 3);
      check("fault_freq_error", freq_error, 1);
      check("fault_sys_n_reset", sys_n_reset, 0);
      finish_period(36, 4);
      pll_lock = 1'b0;
      wait_cycles(3);
      sample();
      check("lockloss_state", state, 0);
      check("lockloss_freq_error", freq_error, 1);
      pll_lock = 1'b1;
      wait_cycles(3);
      sample();
      check("relock_state", state, 1);
      tb_eval = 1'b0;
      release_seq(16);

      // n_reset in RUN
      n_reset = 1'b0;
      step();
      sample();
      check("mid_rst_sys_n_reset", sys_n_reset, 0);
      check("mid_rst_ref_rise", ref_rise, 0);
      check("mid_rst_ref_fall", ref_fall, 0);
      check("mid_rst_period_count", period_count, 0);
      check("mid_rst_freq_error", freq_error, 0);
      check("mid_rst_state", state, 0);
      n_reset = 1'b1;
      wait_cycles(3);
      sample();
      check("post_rst_state", state, 1);

      // MEASURE: 35 is good, 33 clears the good count
      tb_eval = 1'b0;
      for (int i = 0; i < 10; i++) drive_period(36);
      drive_period(35);
      drive_period(33);
      release_seq(16);

      // Reference stops in MEASURE: watchdog at 2*RATIO
      pll_lock = 1'b0;
      wait_cycles(3);
      sample();
      check("wd_lockloss_state", state, 0);
      pll_lock = 1'b1;
      wait_cycles(3);
      sample();
      check("wd_measure_state", state, 1);
      tb_eval = 1'b0;
      for (int i = 0; i < 4; i++) drive_period(36);
      rise_edge();
      wait_cycles(18);
      ref_clk_in = 1'b0;
      wait_cycles(57);
      sample();
      check("wd_before", period_count, 36);
      step();
      sample();
      check("wd_period_count", period_count, 72);
      check("wd_state", state, 1);
      wait_cycles(32);
      prev_len = 36;
      release_seq(15);

      // Lock loss in the same cycle as a bad period in RUN
      drive_period(40);
      rise_edge();
      step();
      pll_lock = 1'b0;
      wait_cycles(2);
      sample();
      check("race_strobe", ref_rise, 1);
      check("race_pre_state", state, 2);
      step();
      sample();
      check("race_state", state, 0);
      check("race_freq_error", freq_error, 0);
      check("race_sys_n_reset", sys_n_reset, 0);
      ref_clk_in = 1'b0;
      wait_cycles(5);
      sample();
      check("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
